// File: rtl/text_scheduler.sv
// text_scheduler
//   Places a fixed box of MSG_LEN character slots on screen and, for every
//   pixel, tells the single-letter renderer which glyph to draw and where
//   inside the glyph the current pixel falls. The message is double-buffered:
//   game logic writes a shadow copy, which is copied into the active copy
//   only at a frame boundary so a frame never shows a half-updated message.
//   A small state machine hides, shows or blinks the whole box.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   pixelX, pixelY    current pixel coordinates from the VGA counters
//   startOfFrame      one-cycle pulse at the first pixel of a frame
//   cmdValid, cmd     visibility command: 00 hide, 01 show, 10 blink, 11 ignored
//   wrEn, wrAddr,
//   wrLetter          write one letter code into the shadow message
//   commit            request shadow->active copy at the next frame start
//   offsetX, offsetY  pixel position inside the glyph (0 when not drawing)
//   letter            glyph code for the renderer (0 when not drawing)
//   drawLetter        renderer enable for this pixel
//   busy              a commit is waiting for the next frame start
//   visible           box currently shown (SHOWN or BLINK_ON)
module text_scheduler #(
  parameter int         MSG_LEN       = 8,
  parameter int         TOP_LEFT_X    = 256,
  parameter int         TOP_LEFT_Y    = 200,
  parameter int         LETTER_WIDTH  = 32,
  parameter int         LETTER_HEIGHT = 32,
  parameter int         SPACING       = 4,
  parameter int         BLINK_FRAMES  = 30,
  parameter logic [3:0] BLANK_CODE    = 4'hF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [10:0]                pixelX,
  input  logic [10:0]                pixelY,
  input  logic                       startOfFrame,
  input  logic                       cmdValid,
  input  logic [1:0]                 cmd,
  input  logic                       wrEn,
  input  logic [$clog2(MSG_LEN)-1:0] wrAddr,
  input  logic [3:0]                 wrLetter,
  input  logic                       commit,
  output logic [10:0]                offsetX,
  output logic [10:0]                offsetY,
  output logic [3:0]                 letter,
  output logic                       drawLetter,
  output logic                       busy,
  output logic                       visible
);

  localparam int PITCH  = LETTER_WIDTH + SPACING;
  localparam int SLOT_W = $clog2(MSG_LEN);
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0] X_LO = 11'(TOP_LEFT_X);
  localparam logic [10:0] X_HI = 11'(TOP_LEFT_X + MSG_LEN * PITCH);
  localparam logic [10:0] Y_LO = 11'(TOP_LEFT_Y);
  localparam logic [10:0] Y_HI = 11'(TOP_LEFT_Y + LETTER_HEIGHT);
  localparam logic [10:0] GLYPH_W = 11'(LETTER_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  localparam logic [1:0] CMD_HIDE  = 2'b00;
  localparam logic [1:0] CMD_SHOW  = 2'b01;
  localparam logic [1:0] CMD_BLINK = 2'b10;

  typedef enum logic [1:0] {HIDDEN, SHOWN, BLINK_ON, BLINK_OFF} state_t;

  state_t           state;
  logic [CNT_W-1:0] blink_cnt;
  logic             vis;
  logic             pending;
  logic [3:0]       shadow [MSG_LEN];
  logic [3:0]       active [MSG_LEN];

  logic [10:0]       rel_x;
  logic [10:0]       rel_y;
  logic [10:0]       off_x;
  logic [SLOT_W-1:0] slot;
  logic [3:0]        code;
  logic              in_box;
  logic              draw;

  logic              vld_p1;
  logic [10:0]       off_x_p1;
  logic [10:0]       off_y_p1;
  logic [3:0]        letter_p1;

  // Slot lookup without a divider: the slot is the last one whose left
  // edge is at or below rel_x. rel_x wraps when left of the box, but
  // in_box masks that case.
  always_comb begin
    rel_x  = pixelX - X_LO;
    rel_y  = pixelY - Y_LO;
    in_box = (pixelY >= Y_LO) && (pixelY < Y_HI) &&
             (pixelX >= X_LO) && (pixelX < X_HI);
    slot   = '0;
    off_x  = rel_x;
    for (int s = 1; s < MSG_LEN; s++) begin
      if (rel_x >= 11'(s * PITCH)) begin
        slot  = SLOT_W'(s);
        off_x = rel_x - 11'(s * PITCH);
      end
    end
    code = active[slot];
    draw = in_box && (off_x < GLYPH_W) && (code != BLANK_CODE) && vis;
  end

  // ---- stage p1: registered renderer request ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      off_x_p1  <= '0;
      off_y_p1  <= '0;
      letter_p1 <= '0;
    end else begin
      vld_p1    <= draw;
      off_x_p1  <= draw ? off_x : '0;
      off_y_p1  <= draw ? rel_y : '0;
      letter_p1 <= draw ? code  : '0;
    end
  end

  // Visibility FSM. A command always takes priority over a frame pulse in
  // the same cycle, so that pulse is not counted toward the blink period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HIDDEN;
      blink_cnt <= '0;
      vis       <= 1'b0;
    end else if (cmdValid && (cmd == CMD_HIDE || cmd == CMD_SHOW || cmd == CMD_BLINK)) begin
      blink_cnt <= '0;
      case (cmd)
        CMD_HIDE: begin
          state <= HIDDEN;
          vis   <= 1'b0;
        end
        CMD_SHOW: begin
          state <= SHOWN;
          vis   <= 1'b1;
        end
        default: begin
          state <= BLINK_ON;
          vis   <= 1'b1;
        end
      endcase
    end else if (startOfFrame && (state == BLINK_ON || state == BLINK_OFF)) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        if (state == BLINK_ON) begin
          state <= BLINK_OFF;
          vis   <= 1'b0;
        end else begin
          state <= BLINK_ON;
          vis   <= 1'b1;
        end
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Message buffers. The frame-start copy reads shadow before any write in
  // the same cycle lands, so a simultaneous write only reaches shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) begin
        shadow[i] <= BLANK_CODE;
        active[i] <= BLANK_CODE;
      end
    end else begin
      if (wrEn && (int'(wrAddr) < MSG_LEN)) begin
        shadow[wrAddr] <= wrLetter;
      end
      if (startOfFrame && (pending || commit)) begin
        for (int i = 0; i < MSG_LEN; i++) begin
          active[i] <= shadow[i];
        end
        pending <= 1'b0;
      end else if (commit) begin
        pending <= 1'b1;
      end
    end
  end

  assign drawLetter = vld_p1;
  assign offsetX    = off_x_p1;
  assign offsetY    = off_y_p1;
  assign letter     = letter_p1;
  assign busy       = pending;
  assign visible    = vis;

endmodule
